// File: rtl/add_stream_pipe_if.sv
// rtl/add_stream_pipe_if.sv - operand/sum stream handshake bundle for add_stream_pipe
interface add_stream_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   y;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/add_stream_pipe.sv
// rtl/add_stream_pipe.sv - pipelined valid/ready unsigned adder with output-transfer counter
// Optional output-sum accumulator enabled by defining ADD_PIPE_ACC_EN.
module add_stream_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  add_stream_pipe_if.slave       bus,
  output logic [CNT_W-1:0]       done_cnt
`ifdef ADD_PIPE_ACC_EN
  ,
  input  logic                   acc_clr,
  output logic [WIDTH+CNT_W-1:0] acc
`endif
);
  localparam int SW = WIDTH + 1;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [SW-1:0]     data_q [STAGES];
  logic [SW-1:0]     data_d [STAGES];
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] vin;
  logic [SW-1:0]     din [STAGES];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              out_xfer;

  // A stage may load when it is empty or its downstream neighbour is moving.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = !v_q[i] || rdy[i+1];
    end
  end

  always_comb begin
    vin    = '0;
    vin[0] = bus.in_valid;
    din[0] = SW'(bus.a) + SW'(bus.b);
    for (int i = 1; i < STAGES; i++) begin
      vin[i] = v_q[i-1];
      din[i] = data_q[i-1];
    end
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    for (int i = 0; i < STAGES; i++) begin
      if (rdy[i]) begin
        v_d[i] = vin[i];
        if (vin[i]) begin
          data_d[i] = din[i];
        end
      end
    end
    out_xfer = v_q[STAGES-1] && bus.out_ready;
    cnt_d    = cnt_q + CNT_W'(out_xfer);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.y         = data_q[STAGES-1];
  assign done_cnt      = cnt_q;

`ifdef ADD_PIPE_ACC_EN
  localparam int AW = WIDTH + CNT_W;

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;

  // Clear wins over an add landing on the same edge.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (out_xfer) begin
      acc_d = acc_q + AW'(data_q[STAGES-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
`endif
endmodule

// File: tb/tb_add_stream_pipe.sv
// tb/tb_add_stream_pipe.sv - randomized scoreboard bench for add_stream_pipe
module tb_add_stream_pipe;
  localparam int W  = 4;
  localparam int ST = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] done_cnt;

  add_stream_pipe_if #(.WIDTH(W)) bus ();

`ifdef ADD_PIPE_ACC_EN
  logic          acc_clr = 1'b0;
  logic [W+CW-1:0] acc;
  longint        exp_acc = 0;
  bit            clr_on_30 = 1'b0;
`endif

  add_stream_pipe #(.WIDTH(W), .STAGES(ST), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .done_cnt (done_cnt)
`ifdef ADD_PIPE_ACC_EN
    ,
    .acc_clr  (acc_clr),
    .acc      (acc)
`endif
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model: FIFO of expected sums plus the edge at which each reaches the output.
  int exp_q[$];
  int due_q[$];
  int exp_done = 0;
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input bit iv, input int ia, input int ib, input bit ordy, output bit took);
    bit exp_ov;
    bit exp_ir;
    int v;
    @(negedge clk);
    exp_ov = (exp_q.size() > 0) && (edge_n >= due_q[0]);
    exp_ir = (exp_q.size() < ST) || ordy;
    bus.in_valid  = iv;
    bus.a         = W'(ia);
    bus.b         = W'(ib);
    bus.out_ready = ordy;
`ifdef ADD_PIPE_ACC_EN
    acc_clr = clr_on_30 && exp_ov && (exp_q[0] == 30);
`endif
    #1;
    check_val("in_ready", bus.in_ready, exp_ir);
    check_val("out_valid", bus.out_valid, exp_ov);
    if (exp_ov) check_val("y", bus.y, exp_q[0]);
    check_val("done_cnt", done_cnt, exp_done);
`ifdef ADD_PIPE_ACC_EN
    check_val("acc", acc, exp_acc[31:0]);
`endif
    v = 0;
    if (exp_ov && ordy) begin
      v = exp_q.pop_front();
      void'(due_q.pop_front());
      exp_done = (exp_done + 1) % (1 << CW);
    end
`ifdef ADD_PIPE_ACC_EN
    if (acc_clr) exp_acc = 0;
    else if (exp_ov && ordy) exp_acc = (exp_acc + v) % (longint'(1) << (W + CW));
`endif
    took = iv && exp_ir;
    if (took) begin
      exp_q.push_back(ia + ib);
      due_q.push_back(edge_n + ST);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit t;
    bit iv;
    bit hold;
    int ca;
    int cb;
    int accepted;
    int cyc;
    int base;
    logic [CW-1:0] delta;
    int pa[4] = '{1, 5, 7, 15};
    int pb[4] = '{3, 6, 8, 15};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_y", bus.y, 0);
    check_val("rst_done", done_cnt, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, t);

    // Back-to-back directed pairs, consumer always ready
    for (int i = 0; i < 4; i++) step(1, pa[i], pb[i], 1, t);
`ifdef ADD_PIPE_ACC_EN
    clr_on_30 = 1'b1;
`endif
    repeat (4) step(0, 0, 0, 1, t);
`ifdef ADD_PIPE_ACC_EN
    clr_on_30 = 1'b0;
`endif
    @(negedge clk); #1;
    check_val("dir_done", done_cnt, 4);
`ifdef ADD_PIPE_ACC_EN
    check_val("acc_after_clr", acc, 0);
    acc_clr = 1'b0;
`endif

    // Output stall: pipeline fills, third pair waits for space
    step(1, 2, 2, 0, t);
    step(1, 3, 3, 0, t);
    step(1, 4, 4, 0, t);
    step(1, 4, 4, 0, t);
    cyc = 0;
    while (!t && cyc < 10) begin
      step(1, 4, 4, 1, t);
      cyc++;
    end
    repeat (5) step(0, 0, 0, 1, t);

    // Randomized traffic on both sides; producer holds a pair until accepted
    base = exp_done; accepted = 0; cyc = 0; hold = 1'b0; iv = 1'b0; ca = 0; cb = 0;
    while (accepted < 1000 && cyc < 20000) begin
      if (!hold) begin
        iv = ($urandom_range(0, 3) != 0);
        ca = $urandom_range(0, (1 << W) - 1);
        cb = $urandom_range(0, (1 << W) - 1);
      end
      step(iv, ca, cb, ($urandom_range(0, 2) != 0), t);
      if (t) accepted++;
      hold = iv && !t;
      cyc++;
    end
    while (exp_q.size() > 0 && cyc < 25000) begin
      step(0, 0, 0, 1, t);
      cyc++;
    end
    @(negedge clk); #1;
    delta = done_cnt - CW'(base);
    check_val("rand_done", delta, 1000);

    // Asynchronous reset with two pairs in flight
    step(1, 9, 9, 0, t);
    step(1, 6, 1, 0, t);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_val("mid_rst_out_valid", bus.out_valid, 0);
    check_val("mid_rst_y", bus.y, 0);
    check_val("mid_rst_done", done_cnt, 0);
    exp_q.delete();
    due_q.delete();
    exp_done = 0;
`ifdef ADD_PIPE_ACC_EN
    exp_acc = 0;
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    repeat (4) step(0, 0, 0, 1, t);
    step(1, 10, 5, 1, t);
    repeat (3) step(0, 0, 0, 1, t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
